// File: rtl/wait_timer_pkg.sv
// ---------------------------------------------------------------------------
// wait_timer_pkg
// Shared definitions for the wait timer bank: the per-channel state
// enumeration and the seconds-counter constants.
// ---------------------------------------------------------------------------
package wait_timer_pkg;

    // Channel lifecycle: IDLE before a session, RUN/PAUSE while a session is
    // open, STOP once the session has ended, SAT when the count is pinned at
    // its maximum.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        STOP  = 3'd3,
        SAT   = 3'd4
    } chanState_e;

    localparam int SEC_W = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/wait_timer_chan.sv
// ---------------------------------------------------------------------------
// wait_timer_chan
// One elapsed-time channel: the state machine, the seconds/minutes counters
// and the registered sat, alarm and stop-event flags.
//
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   tick         - shared 1 s strobe from the prescaler
//   start        - session active (level)
//   work         - station running (level), only meaningful with start high
//   clr          - synchronous clear back to IDLE
//   alarm_min    - alarm threshold in minutes, 0 disables the alarm
//   minute       - elapsed minutes
//   second       - elapsed seconds, 0..59
//   busy         - channel is in RUN or PAUSE
//   sat          - count is pinned at its maximum
//   alarm        - minute has reached alarm_min (registered)
//   stop_pulse   - high for the first cycle spent in STOP
// ---------------------------------------------------------------------------
module wait_timer_chan
    import wait_timer_pkg::*;
#(
    parameter int MIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             work,
    input  logic             clr,
    input  logic [MIN_W-1:0] alarm_min,
    output logic [MIN_W-1:0] minute,
    output logic [SEC_W-1:0] second,
    output logic             busy,
    output logic             sat,
    output logic             alarm,
    output logic             stop_pulse
);

    localparam logic [MIN_W-1:0] MIN_MAX = '1;

    chanState_e       state_q;
    logic [MIN_W-1:0] minute_q;
    logic [SEC_W-1:0] second_q;
    logic             sat_q;
    logic             alarm_q;
    logic             stopPulse_q;

    // Whole channel lives in one sequential block. Counting is only allowed
    // while the registered state is already RUN, so a tick arriving in the
    // same cycle that start/work rises never counts; a falling start/work
    // leaves RUN before the tick can be taken. The alarm compares the
    // current registered minute, which is why it trails minute by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            minute_q    <= '0;
            second_q    <= '0;
            sat_q       <= 1'b0;
            alarm_q     <= 1'b0;
            stopPulse_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            minute_q    <= '0;
            second_q    <= '0;
            sat_q       <= 1'b0;
            alarm_q     <= 1'b0;
            stopPulse_q <= 1'b0;
        end else begin
            stopPulse_q <= 1'b0;
            alarm_q     <= (alarm_min != '0) && (minute_q >= alarm_min);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= work ? RUN : PAUSE;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state_q     <= STOP;
                        stopPulse_q <= 1'b1;
                    end else if (!work) begin
                        state_q <= PAUSE;
                    end else if (tick) begin
                        if (second_q != SEC_MAX) begin
                            second_q <= second_q + 1'b1;
                        end else if (minute_q != MIN_MAX) begin
                            second_q <= '0;
                            minute_q <= minute_q + 1'b1;
                        end else begin
                            // Count is already at max: pin it instead of wrapping.
                            state_q <= SAT;
                            sat_q   <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!start) begin
                        state_q     <= STOP;
                        stopPulse_q <= 1'b1;
                    end else if (work) begin
                        state_q <= RUN;
                    end
                end
                STOP: begin
                    // A new session restarts from zero in a single cycle.
                    if (start) begin
                        state_q  <= work ? RUN : PAUSE;
                        minute_q <= '0;
                        second_q <= '0;
                        sat_q    <= 1'b0;
                    end
                end
                SAT: begin
                    // sat_q deliberately stays set through STOP.
                    if (!start) begin
                        state_q     <= STOP;
                        stopPulse_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign minute     = minute_q;
    assign second     = second_q;
    assign busy       = (state_q == RUN) || (state_q == PAUSE);
    assign sat        = sat_q;
    assign alarm      = alarm_q;
    assign stop_pulse = stopPulse_q;

endmodule

// File: rtl/wait_timer_bank.sv
// ---------------------------------------------------------------------------
// wait_timer_bank
// Bank of independent elapsed-time channels sharing one 1 s prescaler.
//
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   start        - per-channel session active
//   work         - per-channel station running
//   clr          - per-channel synchronous clear
//   alarm_min    - shared alarm threshold in minutes, 0 disables
//   minute       - channel i at [i*MIN_W +: MIN_W]
//   second       - channel i at [i*6 +: 6]
//   busy, sat, alarm, stop_pulse - one bit per channel
// ---------------------------------------------------------------------------
module wait_timer_bank
    import wait_timer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MIN_W    = 16,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       work,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [MIN_W-1:0]          alarm_min,
    output logic [CHANNELS*MIN_W-1:0] minute,
    output logic [CHANNELS*SEC_W-1:0] second,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       sat,
    output logic [CHANNELS-1:0]       alarm,
    output logic [CHANNELS-1:0]       stop_pulse
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] preCnt_q;
    logic             tick;

    // Free-running prescaler; tick marks the last count before wrapping, so
    // the first tick after reset lands TICK_DIV cycles later.
    always_ff @(posedge clk) begin
        if (reset) begin
            preCnt_q <= '0;
        end else if (tick) begin
            preCnt_q <= '0;
        end else begin
            preCnt_q <= preCnt_q + 1'b1;
        end
    end

    assign tick = (preCnt_q == CNT_LAST);

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_chan
        wait_timer_chan #(
            .MIN_W (MIN_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .start      (start[g]),
            .work       (work[g]),
            .clr        (clr[g]),
            .alarm_min  (alarm_min),
            .minute     (minute[g*MIN_W +: MIN_W]),
            .second     (second[g*SEC_W +: SEC_W]),
            .busy       (busy[g]),
            .sat        (sat[g]),
            .alarm      (alarm[g]),
            .stop_pulse (stop_pulse[g])
        );
    end

endmodule

// File: tb/tb_wait_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_wait_timer_bank
// Bench for wait_timer_bank with TICK_DIV=4, CHANNELS=2, MIN_W=4. A model
// tracks each channel as an elapsed-seconds total plus session flags and is
// compared against the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations, followed by a randomized soak.
// ---------------------------------------------------------------------------
module tb_wait_timer_bank;

    localparam int CHANNELS = 2;
    localparam int MIN_W    = 4;
    localparam int TICK_DIV = 4;
    localparam int MAX_EL   = (2**MIN_W) * 60 - 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS-1:0]       work;
    logic [CHANNELS-1:0]       clr;
    logic [MIN_W-1:0]          alarmMin;
    logic [CHANNELS*MIN_W-1:0] minute;
    logic [CHANNELS*6-1:0]     second;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       sat;
    logic [CHANNELS-1:0]       alarm;
    logic [CHANNELS-1:0]       stopPulse;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    wait_timer_bank #(
        .CHANNELS (CHANNELS),
        .MIN_W    (MIN_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .work       (work),
        .clr        (clr),
        .alarm_min  (alarmMin),
        .minute     (minute),
        .second     (second),
        .busy       (busy),
        .sat        (sat),
        .alarm      (alarm),
        .stop_pulse (stopPulse)
    );

    always #5 clk = ~clk;

    // Model state: elapsed seconds, whether a session is open, the sat flag,
    // whether the channel will be counting next cycle, and the event flags.
    int tbCnt;
    bit mTick;
    int mElapsed   [CHANNELS];
    bit mOpen      [CHANNELS];
    bit mSat       [CHANNELS];
    bit mArmed     [CHANNELS];
    bit mStopPulse [CHANNELS];
    bit mAlarm     [CHANNELS];
    bit countNow;
    bit newAlarm;

    // Model advances on each rising edge from the inputs held during the cycle.
    always @(posedge clk) begin
        if (reset) begin
            tbCnt = 0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                mElapsed[ch] = 0; mOpen[ch] = 0; mSat[ch] = 0;
                mArmed[ch] = 0; mStopPulse[ch] = 0; mAlarm[ch] = 0;
            end
        end else begin
            mTick = (tbCnt == TICK_DIV - 1);
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (clr[ch]) begin
                    mElapsed[ch] = 0; mOpen[ch] = 0; mSat[ch] = 0;
                    mArmed[ch] = 0; mStopPulse[ch] = 0; mAlarm[ch] = 0;
                end else begin
                    countNow = mArmed[ch] && mTick && start[ch] && work[ch];
                    newAlarm = (alarmMin != 0) && ((mElapsed[ch] / 60) >= int'(alarmMin));
                    mStopPulse[ch] = 0;
                    if (mOpen[ch]) begin
                        if (!start[ch]) begin
                            mOpen[ch] = 0;
                            mStopPulse[ch] = 1;
                        end else if (countNow) begin
                            if (mElapsed[ch] == MAX_EL) mSat[ch] = 1;
                            else mElapsed[ch] = mElapsed[ch] + 1;
                        end
                    end else if (start[ch]) begin
                        mOpen[ch] = 1;
                        mElapsed[ch] = 0;
                        mSat[ch] = 0;
                    end
                    mArmed[ch] = start[ch] && work[ch] && !mSat[ch];
                    mAlarm[ch] = newAlarm;
                end
            end
            tbCnt = (tbCnt == TICK_DIV - 1) ? 0 : tbCnt + 1;
        end
    end

    int gMin, gSec, eMinM, eSecM;
    bit eBusyM;

    // Every falling edge: compare each channel against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                gMin   = int'(minute[ch*MIN_W +: MIN_W]);
                gSec   = int'(second[ch*6 +: 6]);
                eMinM  = mElapsed[ch] / 60;
                eSecM  = mElapsed[ch] % 60;
                eBusyM = mOpen[ch] && !mSat[ch];
                vectors++;
                if (gMin != eMinM || gSec != eSecM || busy[ch] != eBusyM ||
                    sat[ch] != mSat[ch] || alarm[ch] != mAlarm[ch] ||
                    stopPulse[ch] != mStopPulse[ch]) begin
                    miscompares++;
                    $display("[TB] FAIL model ch%0d t=%0t: got %0d:%0d busy=%b sat=%b alarm=%b stop=%b, expected %0d:%0d busy=%b sat=%b alarm=%b stop=%b",
                             ch, $time, gMin, gSec, busy[ch], sat[ch], alarm[ch], stopPulse[ch],
                             eMinM, eSecM, eBusyM, mSat[ch], mAlarm[ch], mStopPulse[ch]);
                end
            end
        end
    end

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [CHANNELS-1:0] s, input logic [CHANNELS-1:0] w,
                                 input logic [CHANNELS-1:0] c);
        start = s;
        work  = w;
        clr   = c;
    endtask

    task automatic checkOutput(input string name, input int ch, input int eMin, input int eSec,
                               input bit eBusy, input bit eSat, input bit eAlarm, input bit eStop);
        int aMin;
        int aSec;
        aMin = int'(minute[ch*MIN_W +: MIN_W]);
        aSec = int'(second[ch*6 +: 6]);
        vectors++;
        if (aMin != eMin || aSec != eSec || busy[ch] != eBusy || sat[ch] != eSat ||
            alarm[ch] != eAlarm || stopPulse[ch] != eStop) begin
            miscompares++;
            $display("[TB] FAIL %s ch%0d: got %0d:%0d busy=%b sat=%b alarm=%b stop=%b, expected %0d:%0d busy=%b sat=%b alarm=%b stop=%b",
                     name, ch, aMin, aSec, busy[ch], sat[ch], alarm[ch], stopPulse[ch],
                     eMin, eSec, eBusy, eSat, eAlarm, eStop);
        end
    endtask

    initial begin
        bit found;
        reset    = 1'b1;
        alarmMin = '0;
        applyStimulus(2'b00, 2'b00, 2'b00);
        runCycles(2);
        checkEn = 1'b1;
        checkOutput("reset_ch0", 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_ch1", 1, 0, 0, 0, 0, 0, 0);

        // Basic count: ch0 runs from the cycle reset is released.
        reset = 1'b0;
        applyStimulus(2'b01, 2'b01, 2'b00);
        runCycles(240);
        checkOutput("count_60", 0, 1, 0, 1, 0, 0, 0);
        runCycles(4);
        checkOutput("count_61", 0, 1, 1, 1, 0, 0, 0);
        checkOutput("ch1_idle", 1, 0, 0, 0, 0, 0, 0);

        // Pause holds the count for ten ticks, resume counts the next tick.
        applyStimulus(2'b01, 2'b00, 2'b00);
        runCycles(40);
        checkOutput("pause_hold", 0, 1, 1, 1, 0, 0, 0);
        applyStimulus(2'b01, 2'b01, 2'b00);
        runCycles(4);
        checkOutput("resume", 0, 1, 2, 1, 0, 0, 0);

        // Stop then restart.
        applyStimulus(2'b00, 2'b01, 2'b00);
        runCycles(1);
        checkOutput("stop_pulse", 0, 1, 2, 0, 0, 0, 1);
        runCycles(1);
        checkOutput("stop_hold", 0, 1, 2, 0, 0, 0, 0);
        applyStimulus(2'b01, 2'b01, 2'b00);
        runCycles(1);
        checkOutput("restart", 0, 0, 0, 1, 0, 0, 0);

        // Saturation at 15:59, then clear.
        runCycles(3900);
        checkOutput("saturated", 0, 15, 59, 0, 1, 0, 0);
        applyStimulus(2'b01, 2'b01, 2'b01);
        runCycles(1);
        checkOutput("clr_sat", 0, 0, 0, 0, 0, 0, 0);

        // Alarm rises one cycle after minute reaches the threshold.
        applyStimulus(2'b01, 2'b01, 2'b00);
        alarmMin = 4'd2;
        found = 1'b0;
        for (int k = 0; k < 1500 && !found; k++) begin
            runCycles(1);
            if (minute[MIN_W-1:0] == 4'd2) found = 1'b1;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL alarm_wait: minute never reached 2, required 2");
        end else begin
            checkOutput("alarm_lag", 0, 2, 0, 1, 0, 0, 0);
            runCycles(1);
            checkOutput("alarm_set", 0, 2, 0, 1, 0, 1, 0);
        end
        alarmMin = 4'd0;
        runCycles(300);
        vectors++;
        if (alarm[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL alarm_disabled: got %b, required 0", alarm[0]);
        end

        // Clear ch1 exactly in a tick cycle.
        applyStimulus(2'b11, 2'b11, 2'b00);
        runCycles(100);
        for (int k = 0; k < TICK_DIV && tbCnt != TICK_DIV - 1; k++) runCycles(1);
        applyStimulus(2'b11, 2'b11, 2'b10);
        runCycles(1);
        checkOutput("clr_tick_ch1", 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(2'b11, 2'b11, 2'b00);
        runCycles(20);

        // Reset mid-run, then the first tick four cycles after release.
        reset = 1'b1;
        runCycles(1);
        checkOutput("midreset_ch0", 0, 0, 0, 0, 0, 0, 0);
        checkOutput("midreset_ch1", 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        runCycles(3);
        checkOutput("pre_tick", 0, 0, 0, 1, 0, 0, 0);
        runCycles(1);
        checkOutput("first_tick", 0, 0, 1, 1, 0, 0, 0);

        // Randomized soak against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if ($urandom_range(19) == 0) start[ch] = ~start[ch];
                if ($urandom_range(7) == 0) work[ch] = ~work[ch];
                clr[ch] = ($urandom_range(99) == 0);
            end
            if ($urandom_range(199) == 0) alarmMin = MIN_W'($urandom_range(3));
            reset = ($urandom_range(999) == 0);
            runCycles(1);
        end
        reset = 1'b0;
        clr   = '0;
        runCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
